// File: rtl/meas_pkg.sv
// Shared definitions for the measurement frame transmitter: FSM states,
// default header byte and the bytes-per-field helper.
package meas_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        SEQ    = 3'd2,
        F_HIGH = 3'd3,
        F_LOW  = 3'd4,
        F_PER  = 3'd5,
        CSUM   = 3'd6
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    function automatic int calc_nb(input int counter_bits);
        return counter_bits / 8;
    endfunction

endpackage

// File: rtl/meas_byte_mux.sv
// Combinational byte picker: returns byte 'idx' (0 = least significant)
// of a COUNTER_BITS-wide snapshot field.
module meas_byte_mux
    import meas_pkg::*;
#(
    parameter int COUNTER_BITS = 32,
    parameter int IDX_W        = 2
) (
    input  logic [COUNTER_BITS-1:0] field,
    input  logic [IDX_W-1:0]        idx,
    output logic [7:0]              byte_out
);

    localparam int NB = calc_nb(COUNTER_BITS);

    logic [7:0] field_bytes [NB];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign field_bytes[gi] = field[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (idx == IDX_W'(i)) begin
                byte_out = field_bytes[i];
            end
        end
    end

endmodule

// File: rtl/meas_frame_tx.sv
// Snapshots TIME_HIGH/TIME_LOW/PERIOD on START and streams them as an XOR-checked
// byte frame over valid/ready. Define FRAME_SEQ_EN to insert a sequence byte after the header.
module meas_frame_tx
    import meas_pkg::*;
#(
    parameter int         COUNTER_BITS = 32,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [COUNTER_BITS-1:0] TIME_HIGH,
    input  logic [COUNTER_BITS-1:0] TIME_LOW,
    input  logic [COUNTER_BITS-1:0] PERIOD,
    input  logic                    START,
    output logic [7:0]              TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    BUSY,
    output logic                    OVERRUN
);

    localparam int NB    = calc_nb(COUNTER_BITS);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NB - 1);

    state_t                  state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [IDX_W-1:0]        mux_idx;
    logic [COUNTER_BITS-1:0] high_reg, low_reg, per_reg;
    logic [7:0]              csum_reg, tx_data_reg;
    logic [7:0]              high_byte, low_byte, per_byte;
    logic                    tx_valid_reg, busy_reg, overrun_reg, pend_reg;
    logic                    advance, in_field;
`ifdef FRAME_SEQ_EN
    logic [7:0]              seq_reg;
`endif

    assign advance  = tx_valid_reg && TX_READY;
    assign in_field = state_reg inside {F_HIGH, F_LOW, F_PER};
    // Byte to load on the next acceptance: next lower byte of the current
    // field, or the MSB of the following field.
    assign mux_idx  = (in_field && idx_reg != '0) ? idx_reg - IDX_W'(1) : IDX_MAX;

    meas_byte_mux #(.COUNTER_BITS(COUNTER_BITS), .IDX_W(IDX_W)) u_mux_high (
        .field(high_reg), .idx(mux_idx), .byte_out(high_byte)
    );
    meas_byte_mux #(.COUNTER_BITS(COUNTER_BITS), .IDX_W(IDX_W)) u_mux_low (
        .field(low_reg), .idx(mux_idx), .byte_out(low_byte)
    );
    meas_byte_mux #(.COUNTER_BITS(COUNTER_BITS), .IDX_W(IDX_W)) u_mux_per (
        .field(per_reg), .idx(mux_idx), .byte_out(per_byte)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            high_reg     <= '0;
            low_reg      <= '0;
            per_reg      <= '0;
            csum_reg     <= '0;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
            pend_reg     <= 1'b0;
`ifdef FRAME_SEQ_EN
            seq_reg      <= '0;
`endif
        end else begin
            // START in the CSUM-acceptance cycle is a new request, not an overrun.
            overrun_reg <= START && (state_reg != IDLE) && !(state_reg == CSUM && advance);
            if (advance && state_reg != CSUM) begin
                csum_reg <= csum_reg ^ tx_data_reg;
            end
            case (state_reg)
                IDLE: begin
                    if (START || pend_reg) begin
                        high_reg     <= TIME_HIGH;
                        low_reg      <= TIME_LOW;
                        per_reg      <= PERIOD;
                        csum_reg     <= '0;
                        tx_data_reg  <= HDR_BYTE;
                        tx_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        pend_reg     <= 1'b0;
                        state_reg    <= HDR;
                    end
                end
                HDR: begin
                    if (advance) begin
`ifdef FRAME_SEQ_EN
                        tx_data_reg <= seq_reg;
                        state_reg   <= SEQ;
`else
                        tx_data_reg <= high_byte;
                        idx_reg     <= IDX_MAX;
                        state_reg   <= F_HIGH;
`endif
                    end
                end
                SEQ: begin
                    if (advance) begin
                        tx_data_reg <= high_byte;
                        idx_reg     <= IDX_MAX;
                        state_reg   <= F_HIGH;
                    end
                end
                F_HIGH: begin
                    if (advance) begin
                        idx_reg <= mux_idx;
                        if (idx_reg == '0) begin
                            tx_data_reg <= low_byte;
                            state_reg   <= F_LOW;
                        end else begin
                            tx_data_reg <= high_byte;
                        end
                    end
                end
                F_LOW: begin
                    if (advance) begin
                        idx_reg <= mux_idx;
                        if (idx_reg == '0) begin
                            tx_data_reg <= per_byte;
                            state_reg   <= F_PER;
                        end else begin
                            tx_data_reg <= low_byte;
                        end
                    end
                end
                F_PER: begin
                    if (advance) begin
                        idx_reg <= mux_idx;
                        if (idx_reg == '0) begin
                            tx_data_reg <= csum_reg ^ tx_data_reg;
                            state_reg   <= CSUM;
                        end else begin
                            tx_data_reg <= per_byte;
                        end
                    end
                end
                CSUM: begin
                    if (advance) begin
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        pend_reg     <= START;
                        state_reg    <= IDLE;
`ifdef FRAME_SEQ_EN
                        seq_reg      <= seq_reg + 8'd1;
`endif
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    tx_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign TX_DATA  = tx_data_reg;
    assign TX_VALID = tx_valid_reg;
    assign BUSY     = busy_reg;
    assign OVERRUN  = overrun_reg;

endmodule

// File: tb/tb_meas_frame_tx.sv
// Directed bench for meas_frame_tx: basic frame, back-pressure, snapshot,
// overrun, asynchronous reset mid-frame (and sequence bytes when FRAME_SEQ_EN).
module tb_meas_frame_tx;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] TIME_HIGH, TIME_LOW, PERIOD;
    logic        START;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic        OVERRUN;

    int          errors = 0;
    int          checks = 0;
    int          seq_cnt = 0;
    logic [7:0]  exp_q[$];
    bit          bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    meas_frame_tx #(.COUNTER_BITS(32), .HDR_BYTE(8'hA5)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .TIME_HIGH(TIME_HIGH),
        .TIME_LOW (TIME_LOW),
        .PERIOD   (PERIOD),
        .START    (START),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference frame: header, [seq], three fields MSB first, XOR of all prior bytes.
    function automatic void build(input logic [31:0] th, input logic [31:0] tl, input logic [31:0] per);
        logic [31:0] f [3];
        logic [7:0]  c;
        f[0] = th; f[1] = tl; f[2] = per;
        exp_q.delete();
        exp_q.push_back(8'hA5);
`ifdef FRAME_SEQ_EN
        exp_q.push_back(8'(seq_cnt));
`endif
        for (int k = 0; k < 3; k++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(f[k][b*8 +: 8]);
        c = 8'h00;
        foreach (exp_q[i]) c = c ^ exp_q[i];
        exp_q.push_back(c);
    endfunction

    // Adapts a hand-written 14-byte frame to the sequence-byte variant.
    function automatic void seq_fix();
`ifdef FRAME_SEQ_EN
        exp_q.insert(1, 8'(seq_cnt));
        exp_q[exp_q.size()-1] = exp_q[exp_q.size()-1] ^ 8'(seq_cnt);
`endif
    endfunction

    task automatic recv_frame(input string tag, input int bp, input int ovr_at,
                              input int abort_at, input int chg_at, input bit hold_last);
        int         n = 0;
        int         cyc = 0;
        int         ovr_phase = 0;
        bit         stall = 0;
        bit         aborted = 0;
        logic [7:0] held = 8'h00;
        while (n < exp_q.size() && cyc < 100) begin
            TX_READY = (bp != 0) ? bp_pat[cyc % 4] : 1'b1;
            if (cyc == 0) chk({tag, " busy"}, BUSY, 1);
            if (ovr_phase == 1) begin
                chk({tag, " ovr_pulse"}, OVERRUN, 1);
                ovr_phase = 2;
            end else if (ovr_phase == 2) begin
                chk({tag, " ovr_clear"}, OVERRUN, 0);
                ovr_phase = 3;
            end
            if (stall) begin
                chk({tag, " hold_valid"}, TX_VALID, 1);
                chk({tag, " hold_data"}, TX_DATA, held);
            end
            if (n == abort_at) begin
                RST_N = 1'b0;
                #1;
                chk({tag, " async_valid"}, TX_VALID, 0);
                chk({tag, " async_busy"}, BUSY, 0);
                aborted = 1;
                break;
            end
            if (n == chg_at) begin
                TIME_HIGH = 32'h10;
                TIME_LOW  = 32'h20;
                PERIOD    = 32'hDEADBEEF;
            end
            START = ((n == ovr_at && ovr_phase == 0) || (hold_last && n == exp_q.size() - 1)) ? 1'b1 : 1'b0;
            if (n == ovr_at && ovr_phase == 0) ovr_phase = 1;
            stall = 0;
            if (TX_VALID && TX_READY) begin
                chk($sformatf("%s b%0d", tag, n), TX_DATA, exp_q[n]);
                n++;
            end else if (TX_VALID) begin
                held  = TX_DATA;
                stall = 1;
            end
            tick();
            cyc++;
        end
        if (!aborted) begin
            chk({tag, " len"}, n, exp_q.size());
            if (bp == 0) chk({tag, " cycles"}, cyc, exp_q.size());
            seq_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; START = 1'b0; TX_READY = 1'b0;
        TIME_HIGH = '0; TIME_LOW = '0; PERIOD = '0;
        #2;
        chk("rst data", TX_DATA, 0);
        chk("rst valid", TX_VALID, 0);
        chk("rst busy", BUSY, 0);
        chk("rst overrun", OVERRUN, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        chk("idle valid", TX_VALID, 0);
        chk("idle busy", BUSY, 0);

        // Basic frame, hand-written bytes
        TIME_HIGH = 32'h10; TIME_LOW = 32'h20; PERIOD = 32'h30;
        exp_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
                 8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'hA5};
        seq_fix();
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("basic", 0, -1, -1, -1, 0);
        chk("basic end_busy", BUSY, 0);
        chk("basic end_valid", TX_VALID, 0);

        // Back-pressure 1-0-0-1
        build(32'h10, 32'h20, 32'h30);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("bp", 1, -1, -1, -1, 0);
        chk("bp end_busy", BUSY, 0);
        chk("bp end_valid", TX_VALID, 0);

        // Snapshot integrity; START held through CSUM acceptance and the idle cycle
        TIME_HIGH = 32'h11223344; TIME_LOW = 32'h55667788; PERIOD = 32'h99AABBCC;
        build(32'h11223344, 32'h55667788, 32'h99AABBCC);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("snap", 0, -1, -1, 6, 1);
        chk("gap valid", TX_VALID, 0);
        chk("gap overrun", OVERRUN, 0);
        tick();
        START = 1'b0;
        exp_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
                 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hB7};
        seq_fix();
        recv_frame("dbef", 0, -1, -1, -1, 0);

        // Overrun at byte 5
        TIME_HIGH = 32'hAABBCCDD; TIME_LOW = 32'h01020304; PERIOD = 32'h0000FFFF;
        build(32'hAABBCCDD, 32'h01020304, 32'h0000FFFF);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("ovr", 0, 5, -1, -1, 0);
        START = 1'b0;
        repeat (3) tick();
        chk("ovr no_second_valid", TX_VALID, 0);
        chk("ovr no_second_busy", BUSY, 0);
        chk("ovr quiet", OVERRUN, 0);

        // Asynchronous reset at byte 7, then a fresh frame
        build(32'hAABBCCDD, 32'h01020304, 32'h0000FFFF);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("rst", 0, -1, 7, -1, 0);
        START = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        seq_cnt = 0;
        tick();
        chk("post_rst valid", TX_VALID, 0);
        TIME_HIGH = 32'h00000001; TIME_LOW = 32'h00000002; PERIOD = 32'h00000004;
        build(32'h1, 32'h2, 32'h4);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("fresh", 0, -1, -1, -1, 0);
`ifdef FRAME_SEQ_EN
        build(32'h1, 32'h2, 32'h4);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("seq1", 0, -1, -1, -1, 0);
        build(32'h1, 32'h2, 32'h4);
        START = 1'b1; tick(); START = 1'b0;
        recv_frame("seq2", 0, -1, -1, -1, 0);
`endif
        chk("final busy", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
